// File: rtl/exc_ctrl.sv
// Exception/interrupt controller at the MEM/WB boundary: prioritises the leaving
// instruction's faults, synchronised interrupts and ERET, then flushes, drains and redirects.
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR  = 32'hBFC00380,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m_valid,
  input  logic        m_stall,
  input  logic [31:0] m_pc,
  input  logic        m_bd,
  input  logic [6:0]  m_exc,
  input  logic [31:0] m_badaddr,
  input  logic        m_eret,
  input  logic        bus_busy,
  input  logic [5:0]  hw_int,
  input  logic [1:0]  sw_ip,
  input  logic [7:0]  status_im,
  input  logic        status_ie,
  input  logic        status_exl,
  input  logic [31:0] epc_in,
  output logic [5:0]  ip_hw,
  output logic        cp0_en,
  output logic        cp0_bd,
  output logic        cp0_exl,
  output logic [4:0]  cp0_exc,
  output logic [31:0] cp0_epc,
  output logic [31:0] cp0_bva,
  output logic        cp0_eret,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_REDIR = 2'd2;

  logic [1:0]  state;
  logic [5:0]  sync_q [SYNC_STAGES];
  logic        int_pend;
  logic        ev_take;
  logic        ev_eret;
  logic [4:0]  ev_code;
  logic [31:0] ev_bva;
  logic [31:0] ev_epc;
  logic        lat_eret;
  logic        lat_bd;
  logic [4:0]  lat_code;
  logic [31:0] lat_epc;
  logic [31:0] lat_bva;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= hw_int;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign ip_hw    = sync_q[SYNC_STAGES-1];
  assign int_pend = status_ie & ~status_exl & (|({ip_hw, sw_ip} & status_im));

  // Interrupt beats every fault flag; ERET only wins when nothing else is pending.
  always_comb begin
    ev_code = 5'd0;
    ev_bva  = 32'd0;
    ev_eret = 1'b0;
    if (int_pend)      ev_code = 5'd0;
    else if (m_exc[6]) begin ev_code = 5'd4; ev_bva = m_pc; end
    else if (m_exc[5]) ev_code = 5'd10;
    else if (m_exc[4]) ev_code = 5'd12;
    else if (m_exc[3]) ev_code = 5'd8;
    else if (m_exc[2]) ev_code = 5'd9;
    else if (m_exc[1]) begin ev_code = 5'd4; ev_bva = m_badaddr; end
    else if (m_exc[0]) begin ev_code = 5'd5; ev_bva = m_badaddr; end
    else               ev_eret = m_eret;
  end

  assign ev_epc  = m_bd ? (m_pc - 32'd4) : m_pc;
  assign ev_take = (state == S_IDLE) & m_valid & ~m_stall & (int_pend | (|m_exc) | m_eret);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      lat_eret <= 1'b0;
      lat_bd   <= 1'b0;
      lat_code <= 5'd0;
      lat_epc  <= 32'd0;
      lat_bva  <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ev_take) begin
            state    <= bus_busy ? S_DRAIN : S_REDIR;
            lat_eret <= ev_eret;
            lat_bd   <= m_bd;
            lat_code <= ev_code;
            lat_epc  <= ev_epc;
            lat_bva  <= ev_bva;
          end
        end
        S_DRAIN: if (!bus_busy) state <= S_REDIR;
        S_REDIR: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Strobes decode straight from state so an async reset clears them at once.
  assign flush          = (state == S_DRAIN) | (state == S_REDIR);
  assign redirect_valid = (state == S_REDIR);
  assign cp0_en         = redirect_valid & ~lat_eret;
  assign cp0_exl        = redirect_valid & ~lat_eret;
  assign cp0_eret       = redirect_valid & lat_eret;
  assign redirect_pc    = redirect_valid ? (lat_eret ? epc_in : EXC_VECTOR) : 32'd0;
  assign cp0_bd         = lat_bd;
  assign cp0_exc        = lat_code;
  assign cp0_epc        = lat_epc;
  assign cp0_bva        = lat_bva;
  assign dbg_state      = state;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: stimulus pushes expected CP0/redirect records,
// a negedge monitor pops one per redirect strobe and compares.
module tb_exc_ctrl;
  localparam logic [31:0] VEC = 32'hBFC00380;
  localparam int W = 105;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        m_valid = 1'b0, m_stall = 1'b0, m_bd = 1'b0, m_eret = 1'b0;
  logic [31:0] m_pc = '0, m_badaddr = '0, epc_in = 32'h80003000;
  logic [6:0]  m_exc = '0;
  logic        bus_busy = 1'b0, status_ie = 1'b0, status_exl = 1'b0;
  logic [5:0]  hw_int = '0;
  logic [1:0]  sw_ip = '0;
  logic [7:0]  status_im = '0;
  logic [5:0]  ip_hw;
  logic        cp0_en, cp0_bd, cp0_exl, cp0_eret, flush, redirect_valid;
  logic [4:0]  cp0_exc;
  logic [31:0] cp0_epc, cp0_bva, redirect_pc;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail = 0;
  logic prev_rv = 1'b0;
  // {chk_fields, eret, en, exc[4:0], bd, epc[31:0], bva[31:0], redirect_pc[31:0]}
  logic [W-1:0] exp_q[$];

  exc_ctrl #(.EXC_VECTOR(VEC), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .m_valid(m_valid), .m_stall(m_stall), .m_pc(m_pc), .m_bd(m_bd),
    .m_exc(m_exc), .m_badaddr(m_badaddr), .m_eret(m_eret), .bus_busy(bus_busy),
    .hw_int(hw_int), .sw_ip(sw_ip), .status_im(status_im), .status_ie(status_ie),
    .status_exl(status_exl), .epc_in(epc_in), .ip_hw(ip_hw), .cp0_en(cp0_en),
    .cp0_bd(cp0_bd), .cp0_exl(cp0_exl), .cp0_exc(cp0_exc), .cp0_epc(cp0_epc),
    .cp0_bva(cp0_bva), .cp0_eret(cp0_eret), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .dbg_state(dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst) begin
      if (prev_rv) chk("pulse_one_cycle", {redirect_valid, cp0_en, cp0_eret}, 3'b000);
      if (redirect_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_redirect", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_eret", cp0_eret, e[103]);
          chk("sb_en", cp0_en, e[102]);
          chk("sb_exl", cp0_exl, e[102]);
          chk("sb_flush", flush, 1'b1);
          chk("sb_redirect_pc", redirect_pc, e[31:0]);
          if (e[104]) begin
            chk("sb_exc", cp0_exc, e[101:97]);
            chk("sb_bd", cp0_bd, e[96]);
            chk("sb_epc", cp0_epc, e[95:64]);
            chk("sb_bva", cp0_bva, e[63:32]);
          end
        end
      end
    end
    prev_rv = redirect_valid;
  end

  // Driver tasks
  task automatic expect_exc(input logic [4:0] code, input logic bd, input logic [31:0] epc,
                            input logic [31:0] bva);
    exp_q.push_back({1'b1, 1'b0, 1'b1, code, bd, epc, bva, VEC});
  endtask

  task automatic expect_eret(input logic [31:0] tgt);
    exp_q.push_back({1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0, tgt});
  endtask

  task automatic wait_idle();
    int n = 0;
    while (flush && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (flush) chk("idle_timeout", 1'b1, 1'b0);
  endtask

  task automatic send(input logic [31:0] pc, input logic bd, input logic [6:0] exc,
                      input logic [31:0] bad, input logic eret);
    @(negedge clk);
    m_valid = 1'b1; m_pc = pc; m_bd = bd; m_exc = exc; m_badaddr = bad; m_eret = eret;
    @(negedge clk);
    m_valid = 1'b0; m_bd = 1'b0; m_exc = '0; m_badaddr = '0; m_eret = 1'b0;
    wait_idle();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_state"}, dbg_state, 2'd0);
    chk({tag, "_flush"}, flush, 1'b0);
    chk({tag, "_strobes"}, {cp0_en, cp0_eret, cp0_exl, redirect_valid, cp0_bd}, 5'd0);
    chk({tag, "_redirect_pc"}, redirect_pc, 32'd0);
    chk({tag, "_exc"}, cp0_exc, 5'd0);
    chk({tag, "_epc"}, cp0_epc, 32'd0);
    chk({tag, "_bva"}, cp0_bva, 32'd0);
    chk({tag, "_ip_hw"}, ip_hw, 6'd0);
  endtask

  initial begin
    int fcount;
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    rst = 1'b1;

    // Overflow, no bus activity
    expect_exc(5'd12, 1'b0, 32'h80001000, 32'd0);
    send(32'h80001000, 1'b0, 7'b0010000, 32'd0, 1'b0);

    // Delay-slot store fault
    expect_exc(5'd5, 1'b1, 32'h80002000, 32'h00000003);
    send(32'h80002004, 1'b1, 7'b0000001, 32'h00000003, 1'b0);

    // Fetch address fault reports the PC as BadVAddr
    expect_exc(5'd4, 1'b0, 32'h80006001, 32'h80006001);
    send(32'h80006001, 1'b0, 7'b1000000, 32'h12345678, 1'b0);

    // Load fault reports the data address
    expect_exc(5'd4, 1'b0, 32'h80006010, 32'h12345679);
    send(32'h80006010, 1'b0, 7'b0000010, 32'h12345679, 1'b0);

    // Breakpoint outranks a simultaneous load fault; BadVAddr stays 0
    expect_exc(5'd9, 1'b0, 32'h80006020, 32'd0);
    send(32'h80006020, 1'b0, 7'b0000110, 32'h0000ABCD, 1'b0);

    // ERET alone, then ERET masked by reserved instruction
    expect_eret(32'h80003000);
    send(32'h80003100, 1'b0, 7'b0000000, 32'd0, 1'b1);
    expect_exc(5'd10, 1'b0, 32'h80003200, 32'd0);
    send(32'h80003200, 1'b0, 7'b0100000, 32'd0, 1'b1);

    // Exception while EXL=1 is still taken
    status_exl = 1'b1;
    expect_exc(5'd8, 1'b0, 32'h80007000, 32'd0);
    send(32'h80007000, 1'b0, 7'b0001000, 32'd0, 1'b0);
    status_exl = 1'b0;

    // Stalled MEM holds off the event
    @(negedge clk);
    m_valid = 1'b1; m_stall = 1'b1; m_exc = 7'b0000100; m_pc = 32'h80008000;
    @(negedge clk);
    chk("stall_no_event_a", flush, 1'b0);
    @(negedge clk);
    chk("stall_no_event_b", flush, 1'b0);
    expect_exc(5'd9, 1'b0, 32'h80008000, 32'd0);
    m_stall = 1'b0;
    @(negedge clk);
    m_valid = 1'b0; m_exc = '0;
    wait_idle();

    // Syscall with the bus busy for three cycles
    expect_exc(5'd8, 1'b0, 32'h80005000, 32'd0);
    @(negedge clk);
    m_valid = 1'b1; m_exc = 7'b0001000; m_pc = 32'h80005000; bus_busy = 1'b1;
    @(negedge clk);
    m_valid = 1'b0; m_exc = '0;
    fcount = 0;
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) @(negedge clk);
      if (flush) fcount++;
      if (k == 3) chk("drain_rv_early", redirect_valid, 1'b0);
      if (k == 4) chk("drain_rv", redirect_valid, 1'b1);
      if (k == 3) bus_busy = 1'b0;
    end
    chk("drain_flush_cycles", fcount, 32'd4);

    // Hardware interrupt through the synchroniser
    status_ie = 1'b1; status_im = 8'h04;
    @(negedge clk);
    hw_int = 6'b000001;
    @(negedge clk);
    chk("sync_stage1", ip_hw, 6'd0);
    @(negedge clk);
    chk("sync_stage2", ip_hw, 6'd1);
    expect_exc(5'd0, 1'b0, 32'h80004000, 32'd0);
    send(32'h80004000, 1'b0, 7'b0000000, 32'd0, 1'b0);

    // EXL masks the interrupt
    status_exl = 1'b1;
    @(negedge clk);
    m_valid = 1'b1; m_pc = 32'h80004010;
    @(negedge clk);
    chk("int_masked_exl", flush, 1'b0);
    m_valid = 1'b0;
    status_exl = 1'b0;

    // Interrupt beats overflow on the same delay-slot instruction
    expect_exc(5'd0, 1'b1, 32'h80004020, 32'd0);
    send(32'h80004024, 1'b1, 7'b0010000, 32'h0000BEEF, 1'b0);
    hw_int = '0; status_ie = 1'b0;
    repeat (3) @(negedge clk);

    // Reset asserted mid-drain clears everything immediately
    @(negedge clk);
    m_valid = 1'b1; m_exc = 7'b0100000; m_pc = 32'h80009000; bus_busy = 1'b1;
    @(negedge clk);
    m_valid = 1'b0; m_exc = '0;
    @(negedge clk);
    chk("pre_reset_drain", dbg_state, 2'd1);
    rst = 1'b0;
    #1;
    check_reset_outputs("mid_drain");
    @(negedge clk);
    rst = 1'b1; bus_busy = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_reset_idle", flush, 1'b0);

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
